// File: rtl/tx_sched_pkg.sv
// Shared definitions for the Tx DRR frame scheduler.
// State encodings and tuser frame-length field location.
package tx_sched_pkg;

   typedef enum logic [1:0] {
      S_SCAN  = 2'd0,
      S_CHECK = 2'd1,
      S_FWD   = 2'd2
   } state_t;

   localparam int TUSER_LEN_LSB = 0;
   localparam int TUSER_LEN_W   = 16;

   localparam logic [TUSER_LEN_W-1:0] MIN_CHARGE = 16'd1;

endpackage

// File: rtl/axis_mux_nq.sv
// NUM_Q:1 AXI-stream mux with ready demux, selected by queue index.
// Valid and ready are gated so only the forwarding state moves data.
module axis_mux_nq #(
   parameter int NUM_Q = 4
) (
   input  logic [2:0]           i_sel,
   input  logic                 i_fwd,
   input  logic [NUM_Q*64-1:0]  i_s_tdata,
   input  logic [NUM_Q*8-1:0]   i_s_tstrb,
   input  logic [NUM_Q*128-1:0] i_s_tuser,
   input  logic [NUM_Q-1:0]     i_s_tvalid,
   input  logic [NUM_Q-1:0]     i_s_tlast,
   output logic [NUM_Q-1:0]     o_s_tready,
   output logic [63:0]          o_m_tdata,
   output logic [7:0]           o_m_tstrb,
   output logic [127:0]         o_m_tuser,
   output logic                 o_m_tvalid,
   output logic                 o_m_tlast,
   input  logic                 i_m_tready,
   output logic                 o_sel_valid
);

   always_comb begin
      o_m_tdata   = '0;
      o_m_tstrb   = '0;
      o_m_tuser   = '0;
      o_m_tlast   = 1'b0;
      o_sel_valid = 1'b0;
      o_s_tready  = '0;
      for (int q = 0; q < NUM_Q; q++) begin
         if (i_sel == 3'(q)) begin
            o_m_tdata     = i_s_tdata[q*64 +: 64];
            o_m_tstrb     = i_s_tstrb[q*8 +: 8];
            o_m_tuser     = i_s_tuser[q*128 +: 128];
            o_m_tlast     = i_s_tlast[q];
            o_sel_valid   = i_s_tvalid[q];
            o_s_tready[q] = i_fwd & i_m_tready;
         end
      end
      o_m_tvalid = i_fwd & o_sel_valid;
   end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Deficit-round-robin scheduler sharing the MAC Tx stream among NUM_Q
// frame sources; grants are whole frames, fairness is counted in bytes.
module tx_frame_scheduler
   import tx_sched_pkg::*;
#(
   parameter int NUM_Q     = 4,
   parameter int QUANTUM_W = 16,
   parameter int DEFICIT_W = 17
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_Q*64-1:0]        s_axis_tdata,
   input  logic [NUM_Q*8-1:0]         s_axis_tstrb,
   input  logic [NUM_Q*128-1:0]       s_axis_tuser,
   input  logic [NUM_Q-1:0]           s_axis_tvalid,
   input  logic [NUM_Q-1:0]           s_axis_tlast,
   output logic [NUM_Q-1:0]           s_axis_tready,
   output logic [63:0]                m_axis_tdata,
   output logic [7:0]                 m_axis_tstrb,
   output logic [127:0]               m_axis_tuser,
   output logic                       m_axis_tvalid,
   output logic                       m_axis_tlast,
   input  logic                       m_axis_tready,
   input  logic [NUM_Q-1:0]           cfg_enable,
   input  logic [NUM_Q*QUANTUM_W-1:0] cfg_quantum,
   output logic [2:0]                 grant_q,
   output logic                       busy,
   output logic [31:0]                frames_sent
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [2:0]            r_ptr;
   logic [2:0]            w_ptr_nxt;
   logic [2:0]            w_ptr_adv;
   logic [DEFICIT_W-1:0]  r_deficit [NUM_Q];
   logic [31:0]           r_frames;

   logic                  w_fwd;
   logic                  w_sel_valid;
   logic                  w_sel_en;
   logic [QUANTUM_W-1:0]  w_quantum;
   logic [DEFICIT_W-1:0]  w_def;
   logic [DEFICIT_W:0]    w_sum;
   logic [DEFICIT_W-1:0]  w_def_sat;
   logic [TUSER_LEN_W-1:0] w_len_raw;
   logic [DEFICIT_W-1:0]  w_len;
   logic                  w_def_we;
   logic [DEFICIT_W-1:0]  w_def_nxt;
   logic                  w_frame_done;

   assign w_fwd = (r_state == S_FWD);

   axis_mux_nq #(
      .NUM_Q (NUM_Q)
   ) u_mux (
      .i_sel       (r_ptr),
      .i_fwd       (w_fwd),
      .i_s_tdata   (s_axis_tdata),
      .i_s_tstrb   (s_axis_tstrb),
      .i_s_tuser   (s_axis_tuser),
      .i_s_tvalid  (s_axis_tvalid),
      .i_s_tlast   (s_axis_tlast),
      .o_s_tready  (s_axis_tready),
      .o_m_tdata   (m_axis_tdata),
      .o_m_tstrb   (m_axis_tstrb),
      .o_m_tuser   (m_axis_tuser),
      .o_m_tvalid  (m_axis_tvalid),
      .o_m_tlast   (m_axis_tlast),
      .i_m_tready  (m_axis_tready),
      .o_sel_valid (w_sel_valid)
   );

   always_comb begin
      w_sel_en  = 1'b0;
      w_quantum = '0;
      w_def     = '0;
      for (int q = 0; q < NUM_Q; q++) begin
         if (r_ptr == 3'(q)) begin
            w_sel_en  = cfg_enable[q];
            w_quantum = cfg_quantum[q*QUANTUM_W +: QUANTUM_W];
            w_def     = r_deficit[q];
         end
      end
   end

   assign w_ptr_adv = (r_ptr == 3'(NUM_Q-1)) ? 3'd0 : r_ptr + 3'd1;

   // One extra bit catches the carry so the credit saturates, not wraps
   assign w_sum     = {1'b0, w_def} + (DEFICIT_W+1)'(w_quantum);
   assign w_def_sat = w_sum[DEFICIT_W] ? '1 : w_sum[DEFICIT_W-1:0];

   // Zero-length frames are charged a minimum so the round still advances
   assign w_len_raw = m_axis_tuser[TUSER_LEN_LSB +: TUSER_LEN_W];
   assign w_len     = (w_len_raw < MIN_CHARGE) ? DEFICIT_W'(MIN_CHARGE)
                                               : DEFICIT_W'(w_len_raw);

   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_def_we     = 1'b0;
      w_def_nxt    = w_def;
      w_frame_done = 1'b0;
      unique case (r_state)
         S_SCAN: begin
            w_def_we = 1'b1;
            if (w_sel_en && w_sel_valid) begin
               w_def_nxt   = w_def_sat;
               w_state_nxt = S_CHECK;
            end else begin
               w_def_nxt = '0;
               w_ptr_nxt = w_ptr_adv;
            end
         end
         S_CHECK: begin
            if (!w_sel_valid || !w_sel_en) begin
               w_def_we    = 1'b1;
               w_def_nxt   = '0;
               w_ptr_nxt   = w_ptr_adv;
               w_state_nxt = S_SCAN;
            end else if (w_len <= w_def) begin
               w_def_we    = 1'b1;
               w_def_nxt   = w_def - w_len;
               w_state_nxt = S_FWD;
            end else begin
               w_ptr_nxt   = w_ptr_adv;
               w_state_nxt = S_SCAN;
            end
         end
         S_FWD: begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
               w_frame_done = 1'b1;
               w_state_nxt  = S_CHECK;
            end
         end
         default: w_state_nxt = S_SCAN;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_SCAN;
         r_ptr    <= '0;
         r_frames <= '0;
         for (int q = 0; q < NUM_Q; q++) begin
            r_deficit[q] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         if (w_frame_done) begin
            r_frames <= r_frames + 32'd1;
         end
         for (int q = 0; q < NUM_Q; q++) begin
            if (w_def_we && (r_ptr == 3'(q))) begin
               r_deficit[q] <= w_def_nxt;
            end
         end
      end
   end

   assign grant_q     = r_ptr;
   assign busy        = w_fwd;
   assign frames_sent = r_frames;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler: frame sources per queue,
// a beat monitor, and one task per scenario.
module tb_tx_frame_scheduler;

   localparam int NQ = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset_n;
   logic [NQ*64-1:0]    s_tdata;
   logic [NQ*8-1:0]     s_tstrb;
   logic [NQ*128-1:0]   s_tuser;
   logic [NQ-1:0]       s_tvalid;
   logic [NQ-1:0]       s_tlast;
   logic [NQ-1:0]       s_tready;
   logic [63:0]         m_tdata;
   logic [7:0]          m_tstrb;
   logic [127:0]        m_tuser;
   logic                m_tvalid;
   logic                m_tlast;
   logic                m_tready;
   logic [NQ-1:0]       cfg_enable;
   logic [NQ*16-1:0]    cfg_quantum;
   logic [2:0]          grant_q;
   logic                busy;
   logic [31:0]         frames_sent;

   int checks = 0;
   int errors = 0;

   tx_frame_scheduler #(
      .NUM_Q     (NQ),
      .QUANTUM_W (16),
      .DEFICIT_W (17)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tstrb  (s_tstrb),
      .s_axis_tuser  (s_tuser),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tstrb  (m_tstrb),
      .m_axis_tuser  (m_tuser),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .cfg_enable    (cfg_enable),
      .cfg_quantum   (cfg_quantum),
      .grant_q       (grant_q),
      .busy          (busy),
      .frames_sent   (frames_sent)
   );

   // Frame sources: loaded frames are offered beat by beat
   int          src_loaded [NQ];
   int          src_done   [NQ];
   int          src_beat   [NQ];
   int          src_beats  [NQ];
   logic [15:0] src_len    [NQ];
   logic        src_flush;

   always_comb begin
      s_tdata  = '0;
      s_tstrb  = '0;
      s_tuser  = '0;
      s_tvalid = '0;
      s_tlast  = '0;
      for (int q = 0; q < NQ; q++) begin
         s_tvalid[q]          = (src_loaded[q] != src_done[q]);
         s_tlast[q]           = (src_beat[q] == src_beats[q] - 1);
         s_tdata[q*64 +: 64]  = {8'(q), 24'(src_done[q]), 32'(src_beat[q])};
         s_tstrb[q*8 +: 8]    = 8'hff;
         s_tuser[q*128 +: 16] = src_len[q];
      end
   end

   always @(posedge clk) begin
      for (int q = 0; q < NQ; q++) begin
         if (src_flush) begin
            src_done[q] <= src_loaded[q];
            src_beat[q] <= 0;
         end else if (s_tvalid[q] && s_tready[q]) begin
            if (s_tlast[q]) begin
               src_beat[q] <= 0;
               src_done[q] <= src_done[q] + 1;
            end else begin
               src_beat[q] <= src_beat[q] + 1;
            end
         end
      end
   end

   int     mon_beats = 0;
   int     mon_ilv   = 0;
   int     mon_q     = 0;
   logic   mon_in    = 1'b0;
   int     mon_order [$];
   longint mon_bytes [NQ];

   always @(negedge clk) begin
      if (m_tvalid && m_tready) begin
         mon_beats++;
         if (mon_in && int'(m_tdata[63:56]) != mon_q) mon_ilv++;
         if (int'(m_tdata[63:56]) != int'(grant_q)) mon_ilv++;
         mon_q  = int'(m_tdata[63:56]);
         mon_in = !m_tlast;
         if (m_tlast) begin
            mon_order.push_back(mon_q);
            mon_bytes[mon_q] += longint'(m_tuser[15:0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      src_flush = 1'b1;
      tick();
      src_flush = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic load(input int q, input int n, input int beats, input int len);
      src_beats[q]   = beats;
      src_len[q]     = 16'(len);
      src_loaded[q] += n;
   endtask

   task automatic set_all(input logic [15:0] qv);
      cfg_enable = '1;
      for (int q = 0; q < NQ; q++) cfg_quantum[q*16 +: 16] = qv;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      m_tready = 1'b1;
      set_all(16'd0);
      ticks(2);
      checks++;
      if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
      checks++;
      if (s_tready !== 4'b0000) begin errors++; $display("FAIL rst_sready: got %b want 0000", s_tready); end
      checks++;
      if (grant_q !== 3'd0) begin errors++; $display("FAIL rst_grant: got %0d want 0", grant_q); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++;
      if (frames_sent !== 32'd0) begin errors++; $display("FAIL rst_frames: got %0d want 0", frames_sent); end
      reset_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if (grant_q !== 3'(i % 4)) begin
            errors++;
            $display("FAIL empty_ptr%0d: got %0d want %0d", i, grant_q, i % 4);
         end
      end
      checks++;
      if ((dut.r_deficit[0] | dut.r_deficit[1] | dut.r_deficit[2] | dut.r_deficit[3]) !== 17'd0) begin
         errors++;
         $display("FAIL empty_deficit: got nonzero want 0");
      end
   endtask

   task automatic test_single();
      int k;
      set_all(16'd0);
      cfg_quantum[1*16 +: 16] = 16'd1500;
      m_tready = 1'b1;
      do_reset();
      k = 0;
      while (grant_q !== 3'd1 && k < 8) begin tick(); k++; end
      checks++;
      if (grant_q !== 3'd1) begin errors++; $display("FAIL single_wait: got %0d want 1", grant_q); end
      load(1, 1, 3, 20);
      tick();
      checks++;
      if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_lat1: got %b want 0", m_tvalid); end
      tick();
      checks++;
      if (m_tvalid !== 1'b1) begin errors++; $display("FAIL single_lat2: got %b want 1", m_tvalid); end
      checks++;
      if (dut.r_deficit[1] !== 17'd1480) begin
         errors++;
         $display("FAIL single_def: got %0d want 1480", dut.r_deficit[1]);
      end
      checks++;
      if (s_tready !== 4'b0010) begin errors++; $display("FAIL single_sready: got %b want 0010", s_tready); end
      ticks(2);
      checks++;
      if (m_tlast !== 1'b1) begin errors++; $display("FAIL single_tlast: got %b want 1", m_tlast); end
      tick();
      checks++;
      if (frames_sent !== 32'd1) begin errors++; $display("FAIL single_frames: got %0d want 1", frames_sent); end
      tick();
      checks++;
      if (dut.r_deficit[1] !== 17'd0) begin
         errors++;
         $display("FAIL single_def_clr: got %0d want 0", dut.r_deficit[1]);
      end
      checks++;
      if (grant_q !== 3'd2) begin errors++; $display("FAIL single_adv: got %0d want 2", grant_q); end
   endtask

   task automatic test_drr_ratio();
      int     base;
      int     k;
      int     exp;
      longint b0;
      longint b2;
      set_all(16'd0);
      cfg_quantum[0*16 +: 16] = 16'd2000;
      cfg_quantum[2*16 +: 16] = 16'd1000;
      m_tready = 1'b1;
      do_reset();
      base = mon_order.size();
      b0   = mon_bytes[0];
      b2   = mon_bytes[2];
      load(0, 20, 4, 1000);
      load(2, 10, 4, 1000);
      k = 0;
      while (frames_sent !== 32'd30 && k < 1000) begin tick(); k++; end
      checks++;
      if (frames_sent !== 32'd30) begin errors++; $display("FAIL drr_done: got %0d want 30", frames_sent); end
      checks++;
      if (mon_order.size() - base !== 30) begin
         errors++;
         $display("FAIL drr_count: got %0d want 30", mon_order.size() - base);
      end else begin
         for (int i = 0; i < 30; i++) begin
            exp = (i % 3 == 2) ? 2 : 0;
            checks++;
            if (mon_order[base+i] !== exp) begin
               errors++;
               $display("FAIL drr_order%0d: got %0d want %0d", i, mon_order[base+i], exp);
            end
         end
      end
      checks++;
      if (mon_bytes[0] - b0 !== 64'd20000) begin
         errors++;
         $display("FAIL drr_bytes0: got %0d want 20000", mon_bytes[0] - b0);
      end
      checks++;
      if (mon_bytes[2] - b2 !== 64'd10000) begin
         errors++;
         $display("FAIL drr_bytes2: got %0d want 10000", mon_bytes[2] - b2);
      end
   endtask

   task automatic test_accumulate();
      set_all(16'd0);
      cfg_quantum[3*16 +: 16] = 16'd500;
      m_tready = 1'b1;
      do_reset();
      load(3, 1, 2, 1200);
      ticks(5);
      checks++;
      if (dut.r_deficit[3] !== 17'd500) begin errors++; $display("FAIL acc_v1: got %0d want 500", dut.r_deficit[3]); end
      checks++;
      if (grant_q !== 3'd0) begin errors++; $display("FAIL acc_v1_ptr: got %0d want 0", grant_q); end
      ticks(5);
      checks++;
      if (dut.r_deficit[3] !== 17'd1000) begin errors++; $display("FAIL acc_v2: got %0d want 1000", dut.r_deficit[3]); end
      ticks(4);
      checks++;
      if (dut.r_deficit[3] !== 17'd1500) begin errors++; $display("FAIL acc_v3: got %0d want 1500", dut.r_deficit[3]); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL acc_v3_busy: got %b want 0", busy); end
      tick();
      checks++;
      if (busy !== 1'b1 || grant_q !== 3'd3) begin
         errors++;
         $display("FAIL acc_grant: got busy=%b q=%0d want busy=1 q=3", busy, grant_q);
      end
      checks++;
      if (dut.r_deficit[3] !== 17'd300) begin errors++; $display("FAIL acc_after: got %0d want 300", dut.r_deficit[3]); end
   endtask

   task automatic test_no_interleave();
      int base;
      int ilv0;
      int k;
      set_all(16'd1500);
      m_tready = 1'b1;
      do_reset();
      base = mon_order.size();
      ilv0 = mon_ilv;
      load(1, 1, 4, 64);
      ticks(3);
      checks++;
      if (s_tready !== 4'b0010) begin errors++; $display("FAIL ilv_sready: got %b want 0010", s_tready); end
      tick();
      m_tready = 1'b0;
      load(0, 1, 2, 64);
      #1;
      checks++;
      if (s_tready !== 4'b0000) begin errors++; $display("FAIL ilv_stall_rdy: got %b want 0000", s_tready); end
      tick();
      checks++;
      if (busy !== 1'b1 || grant_q !== 3'd1) begin
         errors++;
         $display("FAIL ilv_hold: got busy=%b q=%0d want busy=1 q=1", busy, grant_q);
      end
      checks++;
      if (m_tdata[31:0] !== 32'd1) begin errors++; $display("FAIL ilv_beat: got %0d want 1", m_tdata[31:0]); end
      m_tready = 1'b1;
      k = 0;
      while (frames_sent !== 32'd2 && k < 50) begin tick(); k++; end
      checks++;
      if (mon_order.size() - base !== 2) begin
         errors++;
         $display("FAIL ilv_count: got %0d want 2", mon_order.size() - base);
      end else begin
         checks++;
         if (mon_order[base] !== 1 || mon_order[base+1] !== 0) begin
            errors++;
            $display("FAIL ilv_order: got %0d,%0d want 1,0", mon_order[base], mon_order[base+1]);
         end
      end
      checks++;
      if (mon_ilv !== ilv0) begin errors++; $display("FAIL ilv_mix: got %0d want %0d", mon_ilv, ilv0); end
   endtask

   task automatic test_enable_drop();
      int mb;
      set_all(16'd1500);
      m_tready = 1'b1;
      do_reset();
      mb = mon_beats;
      load(2, 2, 4, 100);
      ticks(4);
      checks++;
      if (busy !== 1'b1 || grant_q !== 3'd2) begin
         errors++;
         $display("FAIL en_grant: got busy=%b q=%0d want busy=1 q=2", busy, grant_q);
      end
      checks++;
      if (dut.r_deficit[2] !== 17'd1400) begin errors++; $display("FAIL en_def: got %0d want 1400", dut.r_deficit[2]); end
      tick();
      cfg_enable[2] = 1'b0;
      ticks(3);
      checks++;
      if (frames_sent !== 32'd1) begin errors++; $display("FAIL en_frames: got %0d want 1", frames_sent); end
      checks++;
      if (mon_beats - mb !== 4) begin errors++; $display("FAIL en_beats: got %0d want 4", mon_beats - mb); end
      tick();
      checks++;
      if (grant_q !== 3'd3) begin errors++; $display("FAIL en_adv: got %0d want 3", grant_q); end
      checks++;
      if (dut.r_deficit[2] !== 17'd0) begin errors++; $display("FAIL en_def_clr: got %0d want 0", dut.r_deficit[2]); end
      ticks(8);
      checks++;
      if (frames_sent !== 32'd1) begin errors++; $display("FAIL en_blocked: got %0d want 1", frames_sent); end
   endtask

   task automatic test_zero_cases();
      set_all(16'd0);
      cfg_quantum[0*16 +: 16] = 16'd1;
      m_tready = 1'b1;
      do_reset();
      load(0, 1, 1, 0);
      load(1, 1, 2, 64);
      ticks(2);
      checks++;
      if (busy !== 1'b1 || grant_q !== 3'd0) begin
         errors++;
         $display("FAIL zlen_grant: got busy=%b q=%0d want busy=1 q=0", busy, grant_q);
      end
      checks++;
      if (dut.r_deficit[0] !== 17'd0) begin errors++; $display("FAIL zlen_charge: got %0d want 0", dut.r_deficit[0]); end
      tick();
      checks++;
      if (frames_sent !== 32'd1) begin errors++; $display("FAIL zlen_frames: got %0d want 1", frames_sent); end
      ticks(20);
      checks++;
      if (frames_sent !== 32'd1) begin errors++; $display("FAIL zq_starved: got %0d want 1", frames_sent); end
      checks++;
      if (dut.r_deficit[1] !== 17'd0) begin errors++; $display("FAIL zq_def: got %0d want 0", dut.r_deficit[1]); end
   endtask

   task automatic test_reset_mid_frame();
      int k;
      set_all(16'd1500);
      m_tready = 1'b1;
      do_reset();
      load(1, 1, 2, 64);
      load(2, 1, 6, 300);
      k = 0;
      while (!(busy === 1'b1 && grant_q === 3'd2) && k < 30) begin tick(); k++; end
      checks++;
      if (busy !== 1'b1 || grant_q !== 3'd2) begin
         errors++;
         $display("FAIL rmid_wait: got busy=%b q=%0d want busy=1 q=2", busy, grant_q);
      end
      ticks(2);
      checks++;
      if (frames_sent !== 32'd1) begin errors++; $display("FAIL rmid_pre: got %0d want 1", frames_sent); end
      reset_n = 1'b0;
      #1;
      checks++;
      if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid: got %b want 0", m_tvalid); end
      checks++;
      if (busy !== 1'b0 || grant_q !== 3'd0) begin
         errors++;
         $display("FAIL rmid_state: got busy=%b q=%0d want busy=0 q=0", busy, grant_q);
      end
      checks++;
      if (frames_sent !== 32'd0) begin errors++; $display("FAIL rmid_frames: got %0d want 0", frames_sent); end
      checks++;
      if (dut.r_deficit[2] !== 17'd0) begin errors++; $display("FAIL rmid_def: got %0d want 0", dut.r_deficit[2]); end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();
      checks++;
      if (grant_q !== 3'd1) begin errors++; $display("FAIL rmid_restart: got %0d want 1", grant_q); end
   endtask

   initial begin
      reset_n     = 1'b0;
      src_flush   = 1'b0;
      m_tready    = 1'b1;
      cfg_enable  = '0;
      cfg_quantum = '0;
      for (int q = 0; q < NQ; q++) begin
         src_loaded[q] = 0;
         src_beats[q]  = 1;
         src_len[q]    = 16'd0;
         mon_bytes[q]  = 0;
      end
      test_reset();
      test_single();
      test_drr_ratio();
      test_accumulate();
      test_no_interleave();
      test_enable_drop();
      test_zero_cases();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
